uart_tx_fifo: RTL and testbench

//  Transmit buffer sitting directly upstream of the UART Tx engine.

---
 rtl/uart_tx_fifo_if.sv | 39 +++
 rtl/uart_tx_fifo.sv | 102 ++++++++++
 tb/tb_uart_tx_fifo.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_fifo_if.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx_fifo_if
//  Purpose  : Host / Tx-engine signal bundle for the UART transmit FIFO.
//             The slave modport is the FIFO; the master modport drives it.
//  Revision : 1.0  initial release
// ============================================================================
interface uart_tx_fifo_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
);
    logic              fifo_en_i;
    logic              clear_i;
    logic              wr_en_i;
    logic [DATA_W-1:0] wr_data_i;
    logic              baud_en_i;
    logic              tx_fifo_pop_i;
    logic              tx_start_o;
    logic [DATA_W-1:0] tx_data_o;
    logic              empty_o;
    logic              full_o;
    logic              almost_full_o;
    logic [ADDR_W:0]   level_o;
    logic              overflow_o;
    logic              underflow_o;

    modport master (
        output fifo_en_i, clear_i, wr_en_i, wr_data_i, baud_en_i, tx_fifo_pop_i,
        input  tx_start_o, tx_data_o, empty_o, full_o, almost_full_o,
               level_o, overflow_o, underflow_o
    );

    modport slave (
        input  fifo_en_i, clear_i, wr_en_i, wr_data_i, baud_en_i, tx_fifo_pop_i,
        output tx_start_o, tx_data_o, empty_o, full_o, almost_full_o,
               level_o, overflow_o, underflow_o
    );
endinterface
`default_nettype wire

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx_fifo
//  Purpose  : Transmit buffer in front of the UART Tx engine. Host writes
//             characters; the engine pops one word per baud-qualified request
//             and samples the registered tx_data_o one clock later.
//  Revision : 1.0  initial release
// ============================================================================
module uart_tx_fifo #(
    parameter int DATA_W       = 8,
    parameter int DEPTH        = 16,
    parameter int ADDR_W       = 4,
    parameter int AFULL_THRESH = 12
) (
    input  wire logic       clk_i,
    input  wire logic       rst_ni,
    uart_tx_fifo_if.slave   bus
);
    localparam logic [ADDR_W:0] c_DEPTH = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] c_AFULL = (ADDR_W+1)'(AFULL_THRESH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W:0]   r_level;
    logic [DATA_W-1:0] r_tx_data;
    logic              r_overflow;
    logic              r_underflow;

    logic w_empty;
    logic w_full;
    logic w_pop_req;
    logic w_pop_ok;
    logic w_wr_ok;

    // Status is taken from the registered level only, so no host/engine
    // strobe has a combinational path to the flags.
    assign w_empty   = (r_level == '0);
    assign w_full    = (r_level == c_DEPTH);

    // A pop request counts only when FIFO mode is on and the baud tick is
    // present; clear overrides both pop and write in the same cycle.
    assign w_pop_req = bus.fifo_en_i & bus.tx_fifo_pop_i & bus.baud_en_i;
    assign w_pop_ok  = ~bus.clear_i & w_pop_req & ~w_empty;
    // A write into a full FIFO is still accepted when a pop frees a slot.
    assign w_wr_ok   = ~bus.clear_i & bus.wr_en_i & (~w_full | w_pop_ok);

    // Storage array; intentionally not reset.
    always_ff @(posedge clk_i) begin
        if (w_wr_ok) begin
            r_mem[r_wr_ptr] <= bus.wr_data_i;
        end
    end

    // Pointers, occupancy, output word and sticky error flags.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_level     <= '0;
            r_tx_data   <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else if (bus.clear_i) begin
            // tx_data_o deliberately keeps the last popped word.
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_level     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_wr_ok) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop_ok) begin
                r_tx_data <= r_mem[r_rd_ptr];
                r_rd_ptr  <= r_rd_ptr + 1'b1;
            end
            case ({w_wr_ok, w_pop_ok})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
            if (bus.wr_en_i & w_full & ~w_pop_ok) begin
                r_overflow <= 1'b1;
            end
            if (w_pop_req & w_empty) begin
                r_underflow <= 1'b1;
            end
        end
    end

    assign bus.tx_start_o    = bus.fifo_en_i & ~w_empty;
    assign bus.tx_data_o     = r_tx_data;
    assign bus.empty_o       = w_empty;
    assign bus.full_o        = w_full;
    assign bus.almost_full_o = (r_level >= c_AFULL);
    assign bus.level_o       = r_level;
    assign bus.overflow_o    = r_overflow;
    assign bus.underflow_o   = r_underflow;
endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_tx_fifo
//  Purpose  : Self-checking bench for uart_tx_fifo against a queue-based
//             reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_uart_tx_fifo;
    localparam int c_DEPTH = 16;
    localparam int c_AFULL = 12;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    uart_tx_fifo_if #(.DATA_W(8), .ADDR_W(4)) bus ();

    uart_tx_fifo #(
        .DATA_W(8), .DEPTH(c_DEPTH), .ADDR_W(4), .AFULL_THRESH(c_AFULL)
    ) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [7:0] q[$];
    logic [7:0] m_tx  = 8'h00;
    logic       m_ovf = 1'b0;
    logic       m_unf = 1'b0;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_tx  = 8'h00;
        m_ovf = 1'b0;
        m_unf = 1'b0;
    endtask

    // Applies the spec's rules for the inputs present at the edge just taken.
    task automatic model_step();
        bit req, can_pop, was_full;
        if (bus.clear_i) begin
            q.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else begin
            req      = bus.fifo_en_i && bus.tx_fifo_pop_i && bus.baud_en_i;
            can_pop  = (q.size() > 0);
            was_full = (q.size() == c_DEPTH);
            if (req && can_pop)  m_tx = q.pop_front();
            if (req && !can_pop) m_unf = 1'b1;
            if (bus.wr_en_i) begin
                if (!was_full || (req && can_pop)) q.push_back(bus.wr_data_i);
                else m_ovf = 1'b1;
            end
        end
    endtask

    task automatic check_all();
        chk("level",    16'(bus.level_o),       16'(q.size()));
        chk("empty",    16'(bus.empty_o),       16'(q.size() == 0));
        chk("full",     16'(bus.full_o),        16'(q.size() == c_DEPTH));
        chk("afull",    16'(bus.almost_full_o), 16'(q.size() >= c_AFULL));
        chk("tx_start", 16'(bus.tx_start_o),    16'(bus.fifo_en_i && q.size() != 0));
        chk("tx_data",  16'(bus.tx_data_o),     16'(m_tx));
        chk("overflow", 16'(bus.overflow_o),    16'(m_ovf));
        chk("underflow",16'(bus.underflow_o),   16'(m_unf));
    endtask

    // One clock: drive inputs, take the edge, update model, check #1 later.
    task automatic cyc(input logic en, input logic clr, input logic we,
                       input logic [7:0] wd, input logic baud, input logic pop);
        bus.fifo_en_i     = en;
        bus.clear_i       = clr;
        bus.wr_en_i       = we;
        bus.wr_data_i     = wd;
        bus.baud_en_i     = baud;
        bus.tx_fifo_pop_i = pop;
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    task automatic wr(input logic [7:0] d);  cyc(1, 0, 1, d, 0, 0); endtask
    task automatic pop1();                   cyc(1, 0, 0, 8'h00, 1, 1); endtask

    initial begin
        logic [7:0] d;
        bus.fifo_en_i = 0; bus.clear_i = 0; bus.wr_en_i = 0;
        bus.wr_data_i = 0; bus.baud_en_i = 0; bus.tx_fifo_pop_i = 0;

        // Reset state
        @(posedge clk); #1;
        check_all();
        chk("rst_empty", 16'(bus.empty_o), 16'd1);
        #3 rst_n = 1'b1;

        // Basic ordering
        wr(8'h41); wr(8'h42); wr(8'h43);
        pop1(); chk("basic_d0", 16'(bus.tx_data_o), 16'h41);
        pop1(); chk("basic_d1", 16'(bus.tx_data_o), 16'h42);
        pop1(); chk("basic_d2", 16'(bus.tx_data_o), 16'h43);
        chk("basic_empty", 16'(bus.empty_o), 16'd1);
        chk("basic_start", 16'(bus.tx_start_o), 16'd0);

        // Fill and overflow
        for (int i = 0; i < c_DEPTH; i++) begin
            wr(8'($urandom));
            if (i == c_AFULL - 1) chk("afull_at_thresh", 16'(bus.almost_full_o), 16'd1);
            if (i == c_AFULL - 2) chk("afull_below", 16'(bus.almost_full_o), 16'd0);
        end
        chk("fill_full", 16'(bus.full_o), 16'd1);
        chk("fill_level", 16'(bus.level_o), 16'd16);
        wr(8'h5A);
        chk("ovf_flag", 16'(bus.overflow_o), 16'd1);
        chk("ovf_level", 16'(bus.level_o), 16'd16);

        // Simultaneous pop and write at full
        cyc(1, 0, 1, 8'hAA, 1, 1);
        chk("sim_level", 16'(bus.level_o), 16'd16);
        chk("sim_full", 16'(bus.full_o), 16'd1);
        for (int i = 0; i < c_DEPTH; i++) pop1();
        chk("sim_last", 16'(bus.tx_data_o), 16'hAA);

        // Underflow and baud gating
        pop1();
        chk("unf_flag", 16'(bus.underflow_o), 16'd1);
        chk("unf_hold", 16'(bus.tx_data_o), 16'hAA);
        cyc(1, 1, 0, 8'h00, 0, 0);
        wr(8'h33);
        cyc(1, 0, 0, 8'h00, 0, 1);
        chk("nobaud_level", 16'(bus.level_o), 16'd1);
        chk("nobaud_unf", 16'(bus.underflow_o), 16'd0);

        // FIFO mode disabled: writes kept, pops ignored
        for (int i = 0; i < 3; i++) cyc(0, 0, 1, 8'($urandom), 1, 1);
        chk("dis_level", 16'(bus.level_o), 16'd4);
        chk("dis_start", 16'(bus.tx_start_o), 16'd0);
        pop1(); chk("dis_order", 16'(bus.tx_data_o), 16'h33);

        // Clear with level 5 and flags set
        cyc(1, 1, 0, 8'h00, 0, 0);
        pop1();
        for (int i = 0; i < 5; i++) wr(8'($urandom));
        chk("pre_clr_level", 16'(bus.level_o), 16'd5);
        cyc(1, 1, 1, 8'h77, 1, 1);
        chk("clr_level", 16'(bus.level_o), 16'd0);
        chk("clr_empty", 16'(bus.empty_o), 16'd1);
        chk("clr_unf", 16'(bus.underflow_o), 16'd0);

        // Pointer wrap with interleaved write/pop
        for (int i = 0; i < 40; i++) begin
            d = 8'($urandom);
            wr(d);
            pop1();
            chk("wrap_data", 16'(bus.tx_data_o), 16'(d));
        end

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            cyc(($urandom_range(0, 9) != 0), ($urandom_range(0, 49) == 0),
                ($urandom_range(0, 1) == 1), 8'($urandom),
                ($urandom_range(0, 4) < 3), ($urandom_range(0, 4) < 3));
        end

        // Async reset mid-clock with level 7
        cyc(1, 1, 0, 8'h00, 0, 0);
        for (int i = 0; i < 6; i++) wr(8'($urandom));
        pop1();
        for (int i = 0; i < 2; i++) wr(8'($urandom));
        chk("pre_rst_level", 16'(bus.level_o), 16'd7);
        #3 rst_n = 1'b0;
        #1;
        model_reset();
        chk("arst_level", 16'(bus.level_o), 16'd0);
        chk("arst_start", 16'(bus.tx_start_o), 16'd0);
        chk("arst_data", 16'(bus.tx_data_o), 16'd0);
        check_all();
        #1 rst_n = 1'b1;
        wr(8'h99); pop1();
        chk("post_rst", 16'(bus.tx_data_o), 16'h99);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1000000;
        fails++;
        $display("FAIL timeout tests=%0d", tests);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "timeout");
    end
endmodule
`default_nettype wire
